// File: rtl/r_instruction.sv
// Single-cycle MIPS R-type datapath: PC, fixed instruction ROM, 32x32 register file, ALU, write-back.
// Optional feature: define R_INSTR_NOR_EN to add funct 39 (nor).
module r_instruction #(
    parameter int IMEM_DEPTH = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [31:0]       inst,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic [DATA_W-1:0] out_ram,
    output logic [31:0]       pc
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    logic [31:0]       r_pc;
    logic [DATA_W-1:0] r_regs [32];
    logic [DATA_W-1:0] r_outRam;

    logic [IDX_W-1:0]  w_index;
    logic [31:0]       w_inst;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [5:0]        w_funct;
    logic [DATA_W-1:0] w_rsData;
    logic [DATA_W-1:0] w_rtData;
    logic [DATA_W-1:0] w_aluResult;
    logic              w_writeEn;

    function automatic logic [31:0] romWord(input logic [IDX_W-1:0] idx);
        case (int'(idx))
            0:       return 32'h0022_1820;
            1:       return 32'h00A3_2022;
            2:       return 32'h00E6_4024;
            3:       return 32'h0101_4825;
            4:       return 32'h0083_502A;
            default: return 32'h0000_0000;
        endcase
    endfunction

    assign w_index = r_pc[IDX_W+1:2];
    assign w_inst  = romWord(w_index);

    assign w_rs    = w_inst[25:21];
    assign w_rt    = w_inst[20:16];
    assign w_rd    = w_inst[15:11];
    assign w_funct = w_inst[5:0];

    // Register $0 is hardwired to zero on read; its storage is never trusted.
    assign w_rsData = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
    assign w_rtData = (w_rt == 5'd0) ? '0 : r_regs[w_rt];

    always_comb begin
        w_aluResult = '0;
        w_writeEn   = 1'b0;
        case (w_funct)
            6'd32: begin
                w_aluResult = w_rsData + w_rtData;
                w_writeEn   = 1'b1;
            end
            6'd34: begin
                w_aluResult = w_rsData - w_rtData;
                w_writeEn   = 1'b1;
            end
            6'd36: begin
                w_aluResult = w_rsData & w_rtData;
                w_writeEn   = 1'b1;
            end
            6'd37: begin
                w_aluResult = w_rsData | w_rtData;
                w_writeEn   = 1'b1;
            end
            6'd42: begin
                w_aluResult = {{(DATA_W-1){1'b0}}, ($signed(w_rsData) < $signed(w_rtData))};
                w_writeEn   = 1'b1;
            end
`ifdef R_INSTR_NOR_EN
            6'd39: begin
                w_aluResult = ~(w_rsData | w_rtData);
                w_writeEn   = 1'b1;
            end
`endif
            default: begin
                w_aluResult = '0;
                w_writeEn   = 1'b0;
            end
        endcase
    end

    // Reset restores the identity register image (reg[i] = i) as well as pc/out_ram.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= 32'd0;
            r_outRam <= '0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= DATA_W'(i);
            end
        end else begin
            r_pc <= r_pc + 32'd4;
            if (w_writeEn) begin
                if (w_rd != 5'd0) begin
                    r_regs[w_rd] <= w_aluResult;
                end
                r_outRam <= w_aluResult;
            end
        end
    end

    assign inst       = w_inst;
    assign rs_data    = w_rsData;
    assign rt_data    = w_rtData;
    assign alu_result = w_aluResult;
    assign zero       = (w_aluResult == '0);
    assign out_ram    = r_outRam;
    assign pc         = r_pc;

endmodule

// File: tb/tb_r_instruction.sv
// Self-checking bench for r_instruction: natural ROM program, random async resets,
// and random R-type instructions injected on the fetch path, all checked against a reference model.
module tb_r_instruction;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] out_ram;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    logic [31:0] mRegs [32];
    logic [31:0] mPc;
    logic [31:0] mOutRam;
    bit          forcing = 1'b0;
    logic [31:0] forcedInst = 32'd0;

    always #5 clk = ~clk;

    r_instruction #(
        .IMEM_DEPTH(32),
        .DATA_W    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .alu_result(alu_result),
        .zero      (zero),
        .out_ram   (out_ram),
        .pc        (pc)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] romWord(input int idx);
        case (idx)
            0:       return 32'h0022_1820;
            1:       return 32'h00A3_2022;
            2:       return 32'h00E6_4024;
            3:       return 32'h0101_4825;
            4:       return 32'h0083_502A;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic bit isSupported(input int funct);
`ifdef R_INSTR_NOR_EN
        return (funct == 32 || funct == 34 || funct == 36 || funct == 37 || funct == 42 || funct == 39);
`else
        return (funct == 32 || funct == 34 || funct == 36 || funct == 37 || funct == 42);
`endif
    endfunction

    function automatic logic [31:0] aluModel(input int funct, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (funct)
            32:      return a + b;
            34:      return a - b;
            36:      return a & b;
            37:      return a | b;
            42:      return (sa < sb) ? 32'd1 : 32'd0;
            39:      return isSupported(39) ? ~(a | b) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] currentInst();
        if (forcing) return forcedInst;
        return romWord(int'((mPc / 4) % 32));
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mRegs[i] = 32'(i);
        mPc     = 32'd0;
        mOutRam = 32'd0;
    endtask

    task automatic checkState(input string tag);
        logic [31:0] w;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        w = currentInst();
        a = mRegs[w[25:21]];
        b = mRegs[w[20:16]];
        r = aluModel(int'(w[5:0]), a, b);
        checkOutput({tag, " inst"}, inst, w);
        checkOutput({tag, " pc"}, pc, mPc);
        checkOutput({tag, " rs_data"}, rs_data, a);
        checkOutput({tag, " rt_data"}, rt_data, b);
        checkOutput({tag, " alu_result"}, alu_result, r);
        checkOutput({tag, " zero"}, {31'd0, zero}, {31'd0, (r == 32'd0)});
        checkOutput({tag, " out_ram"}, out_ram, mOutRam);
    endtask

    // Advance the model across one rising edge with reset released, then move to the next falling edge.
    task automatic stepEdge();
        logic [31:0] w;
        logic [31:0] r;
        w = currentInst();
        r = aluModel(int'(w[5:0]), mRegs[w[25:21]], mRegs[w[20:16]]);
        if (isSupported(int'(w[5:0]))) begin
            if (w[15:11] != 5'd0) mRegs[w[15:11]] = r;
            mOutRam = r;
        end
        mPc = mPc + 32'd4;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            checkState(tag);
            stepEdge();
        end
    endtask

    task automatic asyncReset(input int holdCycles);
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkState("async_rst");
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkState("rst_hold");
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rType(input int rs, input int rt, input int rd, input int funct);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
    endfunction

    task automatic applyStimulus(input logic [31:0] word);
        forcedInst = word;
        forcing    = 1'b1;
        force dut.w_inst = forcedInst;
        #1;
    endtask

    initial begin
        int functTable [8];
        functTable = '{32, 34, 36, 37, 42, 39, 0, 13};

        rst = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkState("reset");
        rst = 1'b1;
        checkOutput("first inst", inst, 32'h0022_1820);
        checkOutput("first alu", alu_result, 32'd3);
        stepEdge();
        checkOutput("first out_ram", out_ram, 32'd3);
        runCycles("prog", 44);

        for (int k = 0; k < 4; k++) begin
            runCycles("prog_rnd", int'($urandom_range(3, 40)));
            asyncReset(int'($urandom_range(0, 2)));
        end
        runCycles("prog_after_rst", 6);

        applyStimulus(rType(0, 1, 11, 34));
        checkState("sub_neg");
        stepEdge();
        applyStimulus(rType(11, 1, 12, 42));
        checkOutput("slt signed", alu_result, 32'd1);
        checkState("slt_signed");
        stepEdge();
        applyStimulus(rType(3, 3, 13, 34));
        checkOutput("sub equal zero", {31'd0, zero}, 32'd1);
        checkState("sub_equal");
        stepEdge();
        applyStimulus(rType(0, 0, 14, 39));
        checkState("funct39");
        stepEdge();
        applyStimulus(rType(1, 2, 0, 32));
        checkState("write_r0");
        stepEdge();
        applyStimulus(rType(0, 0, 15, 32));
        checkOutput("r0 reads zero", rs_data, 32'd0);
        checkState("read_r0");
        stepEdge();
        applyStimulus(rType(5, 5, 5, 32));
        checkState("rdw_1");
        stepEdge();
        applyStimulus(rType(5, 0, 16, 37));
        checkState("rdw_2");
        stepEdge();

        for (int i = 0; i < 300; i++) begin
            logic [31:0] word;
            word = rType(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 31)), functTable[$urandom_range(0, 7)]);
            word[31:26] = 6'($urandom);
            word[10:6]  = 5'($urandom);
            applyStimulus(word);
            checkState("rand");
            stepEdge();
        end

        applyStimulus(rType(1, 1, 3, 32));
        checkState("set_r3");
        stepEdge();
        applyStimulus(rType(3, 3, 0, 37));
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("rst r3 restored", rs_data, 32'd3);
        checkOutput("rst pc", pc, 32'd0);
        checkOutput("rst out_ram", out_ram, 32'd0);
        checkState("rst_forced");
        @(negedge clk);
        rst = 1'b1;

        release dut.w_inst;
        forcing = 1'b0;
        #1;
        runCycles("prog_final", 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
